// File: rtl/alu_sequencer.sv
// Sequences 16/32-bit ops over an external 16-bit ALU; done at N+2 (16b), N+3 (32b), N+1 (illegal) after accept edge N.
// No backpressure: req is sampled only in IDLE and ignored while busy.
module alu_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [3:0]  opcode,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        use_cflag,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cflag,
    output logic        zflag,
    output logic        err,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [9:0]  alu_sel,
    output logic        alu_cin,
    input  logic [15:0] alu_out,
    input  logic        alu_cout,
    input  logic        alu_zout
);

    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

    state_t      state;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        usec_q;
    logic [15:0] lo_q;
    logic        cout_lo;
    logic        zout_lo;
    logic        is32;

    assign is32 = (op_q == 4'd10) || (op_q == 4'd11);

    // Opcodes 0..9 map onto select bits 9..0; the 32-bit ops reuse add/sub.
    function automatic logic [9:0] sel_of(input logic [3:0] op);
        case (op)
            4'd10:   sel_of = 10'b00_0000_1000;
            4'd11:   sel_of = 10'b00_0000_0100;
            default: sel_of = (op <= 4'd9) ? (10'b10_0000_0000 >> op) : 10'b0;
        endcase
    endfunction

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_sel = '0;
        alu_cin = 1'b0;
        case (state)
            LO: begin
                alu_a   = a_q[15:0];
                alu_b   = b_q[15:0];
                alu_sel = sel_of(op_q);
                alu_cin = usec_q & cflag;
            end
            HI: begin
                alu_a   = a_q[31:16];
                alu_b   = b_q[31:16];
                alu_sel = sel_of(op_q);
                alu_cin = cout_lo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            cflag   <= 1'b0;
            zflag   <= 1'b0;
            err     <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            usec_q  <= 1'b0;
            lo_q    <= '0;
            cout_lo <= 1'b0;
            zout_lo <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q   <= opcode;
                        a_q    <= opa;
                        b_q    <= opb;
                        usec_q <= use_cflag;
                        busy   <= 1'b1;
                        if (opcode > 4'd11) begin
                            // Illegal op: flag it and leave result/flags alone.
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= FIN;
                        end else begin
                            state <= LO;
                        end
                    end
                end
                LO: begin
                    if (is32) begin
                        lo_q    <= alu_out;
                        cout_lo <= alu_cout;
                        zout_lo <= alu_zout;
                        state   <= HI;
                    end else begin
                        result <= {16'h0000, alu_out};
                        cflag  <= alu_cout;
                        zflag  <= alu_zout;
                        err    <= 1'b0;
                        done   <= 1'b1;
                        state  <= FIN;
                    end
                end
                HI: begin
                    result <= {alu_out, lo_q};
                    cflag  <= alu_cout;
                    zflag  <= zout_lo & alu_zout;
                    err    <= 1'b0;
                    done   <= 1'b1;
                    state  <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural ALU device, directed vector table, corner sequences, random ops vs model.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset, req, use_cflag;
    logic [3:0]  opcode;
    logic [31:0] opa, opb;
    logic        busy, done, cflag, zflag, err;
    logic [31:0] result;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [9:0]  alu_sel;
    logic        alu_cin, alu_cout, alu_zout;

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side view of the architectural flags.
    logic [31:0] mr = '0;
    logic        mc = 1'b0;
    logic        mz = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .reset(reset), .req(req), .opcode(opcode), .opa(opa), .opb(opb),
        .use_cflag(use_cflag), .busy(busy), .done(done), .result(result), .cflag(cflag),
        .zflag(zflag), .err(err), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout), .alu_zout(alu_zout)
    );

    // External 16-bit ALU device.
    logic [16:0] alu_s;
    logic [31:0] alu_p;
    always_comb begin
        alu_s    = '0;
        alu_p    = '0;
        alu_out  = '0;
        alu_cout = 1'b0;
        case (alu_sel)
            10'b1000000000: alu_out = alu_b;
            10'b0100000000: alu_out = alu_a & alu_b;
            10'b0010000000: alu_out = alu_a | alu_b;
            10'b0001000000: alu_out = ~alu_b;
            10'b0000100000: begin alu_out = {alu_b[14:0], 1'b0}; alu_cout = alu_b[15]; end
            10'b0000010000: begin alu_out = {1'b0, alu_b[15:1]}; alu_cout = alu_b[0]; end
            10'b0000001000: begin
                alu_s = {1'b0, alu_a} + {1'b0, alu_b} + {16'h0, alu_cin};
                alu_out = alu_s[15:0]; alu_cout = alu_s[16];
            end
            10'b0000000100: begin
                alu_s = {1'b0, alu_a} - {1'b0, alu_b} - {16'h0, alu_cin};
                alu_out = alu_s[15:0]; alu_cout = alu_s[16];
            end
            10'b0000000010: begin alu_p = alu_a * alu_b; alu_out = alu_p[15:0]; end
            10'b0000000001: begin alu_out = alu_a; alu_cout = (alu_a > alu_b); end
            default: ;
        endcase
        alu_zout = (alu_out == 16'h0000);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Architectural reference: whole-word arithmetic, no notion of passes or states.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic u, input logic [31:0] pr, input logic pc, input logic pz,
                                  output logic [31:0] r, output logic c, output logic z,
                                  output logic e, output int lat);
        logic [15:0] aa, bb;
        logic        cin;
        logic [16:0] d17;
        logic [32:0] d33;
        logic [31:0] p;
        aa = a[15:0]; bb = b[15:0]; cin = u & pc;
        r = pr; c = pc; z = pz; e = 1'b0; lat = 2;
        case (op)
            4'd0: begin r = {16'h0, bb}; c = 1'b0; end
            4'd1: begin r = {16'h0, aa & bb}; c = 1'b0; end
            4'd2: begin r = {16'h0, aa | bb}; c = 1'b0; end
            4'd3: begin r = {16'h0, ~bb}; c = 1'b0; end
            4'd4: begin r = {16'h0, bb[14:0], 1'b0}; c = bb[15]; end
            4'd5: begin r = {17'h0, bb[15:1]}; c = bb[0]; end
            4'd6: begin d17 = aa + bb + cin; r = {16'h0, d17[15:0]}; c = d17[16]; end
            4'd7: begin d17 = aa - bb - cin; r = {16'h0, d17[15:0]}; c = d17[16]; end
            4'd8: begin p = aa * bb; r = {16'h0, p[15:0]}; c = 1'b0; end
            4'd9: begin r = {16'h0, aa}; c = (aa > bb); end
            4'd10: begin d33 = a + b + cin; r = d33[31:0]; c = d33[32]; lat = 3; end
            4'd11: begin d33 = a - b - cin; r = d33[31:0]; c = d33[32]; lat = 3; end
            default: begin e = 1'b1; lat = 1; end
        endcase
        if (!e) z = (r == 32'h0);
    endfunction

    function automatic logic [9:0] exp_sel(input logic [3:0] op);
        logic [9:0] one;
        one = 10'b10_0000_0000;
        if (op == 4'd10) return 10'b00_0000_1000;
        if (op == 4'd11) return 10'b00_0000_0100;
        return one >> op;
    endfunction

    task automatic check_quiet(input string nm);
        chk({nm, " busy"}, {31'h0, busy}, 32'h0);
        chk({nm, " done"}, {31'h0, done}, 32'h0);
        chk({nm, " result"}, result, 32'h0);
        chk({nm, " flags"}, {29'h0, cflag, zflag, err}, 32'h0);
        chk({nm, " alu"}, {alu_sel, alu_a, alu_b, alu_cin}, 43'h0);
    endtask

    // Issue one op with a single-cycle req and check its whole lifetime.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic u, input logic [31:0] er, input logic ec, input logic ez,
                          input logic ee, input int elat, input string nm);
        logic        lo_cin, hi_cin;
        logic [16:0] lo17;
        bit          got;
        int          lat;
        lo_cin = u & mc;
        lo17 = (op == 4'd11) ? (a[15:0] - b[15:0] - lo_cin) : (a[15:0] + b[15:0] + lo_cin);
        hi_cin = lo17[16];
        @(negedge clk);
        req = 1'b1; opcode = op; opa = a; opb = b; use_cflag = u;
        @(posedge clk);
        #1;
        req = 1'b0; opcode = 4'($urandom); opa = $urandom; opb = $urandom; use_cflag = 1'($urandom);
        got = 0; lat = 0;
        for (int j = 0; j < 6 && !got; j++) begin
            @(negedge clk);
            chk({nm, " busy"}, {31'h0, busy}, 32'h1);
            if (done) begin
                got = 1; lat = j + 1;
            end else if (j < 2) begin
                chk({nm, " alu_sel"}, {22'h0, alu_sel}, {22'h0, exp_sel(op)});
                chk({nm, " alu_cin"}, {31'h0, alu_cin}, {31'h0, (j == 0) ? lo_cin : hi_cin});
                chk({nm, " alu_a"}, {16'h0, alu_a}, {16'h0, (j == 0) ? a[15:0] : a[31:16]});
            end
        end
        if (!got) begin
            chk({nm, " done timeout"}, 32'h0, 32'h1);
        end else begin
            chk({nm, " latency"}, lat, elat);
            chk({nm, " result"}, result, er);
            chk({nm, " cflag/zflag/err"}, {29'h0, cflag, zflag, err}, {29'h0, ec, ez, ee});
            chk({nm, " alu_sel in FIN"}, {22'h0, alu_sel}, 32'h0);
            @(negedge clk);
            chk({nm, " done pulse width"}, {30'h0, done, busy}, 32'h0);
        end
        mr = er; mc = ec; mz = ez;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        u;
        logic [31:0] r;
        logic        c, z, e;
        int          lat;
    } vec_t;

    vec_t tbl[17];

    logic [31:0] rr;
    logic        rc, rz, re;
    int          rl, ndone;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{4'd6,  32'h0000FFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b0, 2};
        tbl[1]  = '{4'd10, 32'h0001FFFF, 32'h00000001, 1'b0, 32'h00020000, 1'b0, 1'b0, 1'b0, 3};
        tbl[2]  = '{4'd9,  32'h00000005, 32'h00000002, 1'b0, 32'h00000005, 1'b1, 1'b0, 1'b0, 2};
        tbl[3]  = '{4'd7,  32'h00000005, 32'h00000002, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b0, 2};
        tbl[4]  = '{4'd13, 32'hDEADBEEF, 32'h12345678, 1'b1, 32'h00000002, 1'b0, 1'b0, 1'b1, 1};
        tbl[5]  = '{4'd1,  32'h000000F0, 32'h00000FF0, 1'b0, 32'h000000F0, 1'b0, 1'b0, 1'b0, 2};
        tbl[6]  = '{4'd0,  32'hFFFF0000, 32'hAAAA1234, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0, 2};
        tbl[7]  = '{4'd3,  32'h00000000, 32'h0000FFFF, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 2};
        tbl[8]  = '{4'd4,  32'h00000000, 32'h00008001, 1'b0, 32'h00000002, 1'b1, 1'b0, 1'b0, 2};
        tbl[9]  = '{4'd5,  32'h00000000, 32'h00000003, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0, 2};
        tbl[10] = '{4'd8,  32'h00000100, 32'h00000100, 1'b0, 32'h00000000, 1'b0, 1'b1, 1'b0, 2};
        tbl[11] = '{4'd11, 32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 3};
        tbl[12] = '{4'd7,  32'h00000000, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b1, 1'b0, 1'b0, 2};
        tbl[13] = '{4'd10, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0, 3};
        tbl[14] = '{4'd2,  32'hABCD00FF, 32'h1234FF00, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 2};
        tbl[15] = '{4'd15, 32'h00000001, 32'h00000001, 1'b0, 32'h0000FFFF, 1'b0, 1'b0, 1'b1, 1};
        tbl[16] = '{4'd9,  32'h00000003, 32'h00000003, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b0, 2};

        reset = 1'b1; req = 1'b0; opcode = '0; opa = '0; opb = '0; use_cflag = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        reset = 1'b0;

        for (int i = 0; i < 17; i++)
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].u, tbl[i].r, tbl[i].c, tbl[i].z,
                   tbl[i].e, tbl[i].lat, $sformatf("vec%0d", i));

        // req held high: ADD 1+1 re-accepted every third cycle (LO, FIN, IDLE).
        @(negedge clk);
        req = 1'b1; opcode = 4'd6; opa = 32'h1; opb = 32'h1; use_cflag = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
            chk($sformatf("held req alu_sel k=%0d", k), {22'h0, alu_sel},
                (k % 3 == 0) ? 32'h008 : 32'h0);
            chk($sformatf("held req done k=%0d", k), {31'h0, done}, {31'h0, (k % 3 == 1)});
        end
        req = 1'b0;
        chk("held req done count", ndone, 4);
        chk("held req result", result, 32'h2);
        mr = 32'h2; mc = 1'b0; mz = 1'b0;
        @(negedge clk);

        // Reset during the HI pass of ADD32 aborts without a done pulse.
        req = 1'b1; opcode = 4'd10; opa = 32'h0001FFFF; opb = 32'h1; use_cflag = 1'b0;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort in HI alu_cin", {31'h0, alu_cin}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("abort");
        reset = 1'b0;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", ndone, 0);
        mr = '0; mc = 1'b0; mz = 1'b0;
        run_op(4'd0, 32'h0, 32'h00001234, 1'b0, 32'h00001234, 1'b0, 1'b0, 1'b0, 2, "movb after abort");

        // Randomised ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic        u;
            op = 4'($urandom_range(0, 15));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            u = 1'($urandom);
            model(op, a, b, u, mr, mc, mz, rr, rc, rz, re, rl);
            run_op(op, a, b, u, rr, rc, rz, re, rl, $sformatf("rnd%0d op%0d", i, op));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high (ports clk, reset).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous, active-high; sampled on rising clk.
REQ-004 req  in  1  operation request, sampled only in IDLE.
REQ-005 opcode  in  4  0 MOVB, 1 AND, 2 OR, 3 NOT, 4 SHL, 5 SHR, 6 ADD, 7 SUB, 8 MUL, 9 CMP, 10 ADD32, 11 SUB32, 12-15 illegal.
REQ-006 opa  in  32  operand A; bits 31:16 used only by ADD32/SUB32.
REQ-007 opb  in  32  operand B; bits 31:16 used only by ADD32/SUB32.
REQ-008 use_cflag  in  1  1 = first ALU pass takes cin from cflag, 0 = cin 0.
REQ-009 busy  out  1  high from the cycle after acceptance through the done cycle.
REQ-010 done  out  1  one-cycle pulse; result, flags and err valid in that cycle.
REQ-011 result  out  32  registered result; bits 31:16 zero for 16-bit ops.
REQ-012 cflag  out  1  registered carry flag.
REQ-013 zflag  out  1  registered zero flag.
REQ-014 err  out  1  registered; set for an illegal opcode, cleared by the next legal op.
REQ-015 alu_a, alu_b  out  16  ALU operands.
REQ-016 alu_sel  out  10  one-hot ALU select; bit9..0 = B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB.
REQ-017 alu_cin  out  1  ALU carry-in.
REQ-018 alu_out  in  16, alu_cout in 1, alu_zout in 1: ALU results, combinational from the alu_* outputs.

Function
REQ-019 States SHALL be IDLE, LO, HI, FIN; only one op in flight.
REQ-020 IDLE with req=1 SHALL latch opcode, opa, opb and use_cflag and go to LO; req while busy SHALL be ignored.
REQ-021 Illegal opcode SHALL go IDLE->FIN directly: err=1, result, cflag and zflag unchanged, no ALU pass.
REQ-022 LO SHALL drive alu_a=opa[15:0], alu_b=opb[15:0], alu_sel per opcode (ADD32->AaddB, SUB32->AsubB), alu_cin=use_cflag&cflag; at clk end it SHALL capture alu_out, alu_cout and alu_zout.
REQ-023 LO SHALL go to HI for ADD32/SUB32 and to FIN otherwise.
REQ-024 HI SHALL drive alu_a=opa[31:16], alu_b=opb[31:16] and the same alu_sel, with alu_cin = cout captured in LO; it SHALL capture the high word and go to FIN.
REQ-025 FIN SHALL assert done for exactly one cycle with result, cflag and zflag updated; it SHALL return to IDLE and SHALL NOT accept req in the FIN cycle.
REQ-026 cflag SHALL equal the cout of the last ALU pass, including 0 for MOVB/AND/OR/NOT/MUL.
REQ-027 zflag SHALL equal alu_zout for 16-bit ops and zout_lo AND zout_hi for 32-bit ops.
REQ-028 CMP SHALL set result[15:0]=opa[15:0] and cflag=(A>B, unsigned).
REQ-029 Latency: req accepted at edge N gives done at edge N+2 for 16-bit ops, N+3 for 32-bit ops, and N+1 for illegal opcodes.
REQ-030 alu_sel SHALL be all-zero, and alu_a, alu_b and alu_cin SHALL be zero, outside LO/HI.
REQ-031 All outputs SHALL be registered except the alu_* outputs, which decode from state and latched operands.

Reset
REQ-032 reset SHALL force IDLE, busy=0, done=0, result=0, cflag=0, zflag=0, err=0 and alu_sel=0.
REQ-033 reset in LO, HI or FIN SHALL abort the op with no done pulse; the first req after reset deasserts SHALL be accepted normally.

Verification
REQ-034 ADD, opa=0x0000FFFF, opb=0x00000001, use_cflag=0 -> done at N+2, result=0x00000000, cflag=1, zflag=1.
REQ-035 ADD32, opa=0x0001FFFF, opb=0x00000001 -> HI alu_cin=1, done at N+3, result=0x00020000, cflag=0, zflag=0.
REQ-036 SUB, use_cflag=1, cflag=1, opa=5, opb=2 -> alu_cin=1 in LO, result=0x00000002, cflag=0.
REQ-037 opcode 13 -> done at N+1, err=1, result/flags unchanged; following AND 0x00F0&0x0FF0 -> result=0x000000F0, err=0.
REQ-038 req held high through an op -> exactly one done per accepted op, a new accept in the IDLE cycle after FIN, alu_sel one-hot only in LO/HI.
REQ-039 reset asserted in HI of ADD32 -> no done, all outputs zero the next cycle; a following MOVB opb=0x1234 -> result=0x00001234.
